// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares one single-port framebuffer RAM between CPU writes and the
// once-per-line fetch that copies one framebuffer row into the idle bank
// of a double-buffered line buffer during horizontal blank.
//
// Ports
//   clk_50     system clock, rising edge
//   rst_n      synchronous active-low reset
//   h_cnt      VGA horizontal counter (advances every second clk_50)
//   v_cnt      VGA vertical counter
//   wr_req     CPU write request, held with wr_addr/wr_data until wr_ack
//   wr_addr    CPU framebuffer address
//   wr_data    CPU write data
//   wr_ack     one-cycle pulse in the cycle the write hits the RAM
//   ram_addr   framebuffer RAM address
//   ram_we     framebuffer RAM write enable
//   ram_wdata  framebuffer RAM write data
//   ram_rdata  framebuffer RAM read data (one cycle latency)
//   lb_we      line-buffer write enable
//   lb_addr    line-buffer address {bank, column}
//   lb_wdata   line-buffer write data
//   disp_bank  line-buffer bank currently scanned out
//   busy       arbiter not idle
//   fetch_err  sticky: a line trigger arrived while a fetch was running
//
// state | meaning
// IDLE  | waiting for a line trigger or a CPU write
// WRITE | CPU write presented to the RAM for one cycle
// FETCH | one RAM read per cycle, columns 0..FB_WIDTH-1
// DRAIN | last read data lands in the line buffer

module vga_fb_arbiter #(
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 144,
    parameter int V_SCALE   = 3,
    parameter int V_TOP     = 24,
    parameter int FETCH_H   = 640
) (
    input  logic        clk_50,
    input  logic        rst_n,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        wr_req,
    input  logic [14:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    output logic [14:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic        lb_we,
    output logic [8:0]  lb_addr,
    output logic [7:0]  lb_wdata,
    output logic        disp_bank,
    output logic        busy,
    output logic        fetch_err
);

    localparam int REP_W = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;

    // The fetch for display line v happens during the blank of line v-1,
    // hence the window is shifted up by one line.
    localparam logic [9:0]       V_FIRST  = 10'(V_TOP - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOP + FB_HEIGHT * V_SCALE - 2);
    localparam logic [9:0]       FETCH_HC = 10'(FETCH_H);
    localparam logic [7:0]       COL_LAST = 8'(FB_WIDTH - 1);
    localparam logic [14:0]      ROW_STEP = 15'(FB_WIDTH);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(V_SCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FETCH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [9:0]       h_prev_q, h_prev_d;
    logic             pending_q, pending_d;
    logic [7:0]       col_q, col_d;
    logic [14:0]      row_base_q, row_base_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             lb_we_q, lb_we_d;
    logic [7:0]       lb_col_q, lb_col_d;
    logic             disp_bank_q, disp_bank_d;
    logic             fetch_err_q, fetch_err_d;

    logic trig;
    logic fetching;

    // h_cnt holds each value for two clocks; comparing against the previous
    // sample yields one trigger per line.
    assign trig = (h_cnt == FETCH_HC) && (h_prev_q != FETCH_HC) &&
                  (v_cnt >= V_FIRST) && (v_cnt <= V_LAST);

    assign fetching = (state_q == ST_FETCH) || (state_q == ST_DRAIN);

    // state register and datapath flops
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            h_prev_q    <= '0;
            pending_q   <= 1'b0;
            col_q       <= '0;
            row_base_q  <= '0;
            rep_q       <= '0;
            lb_we_q     <= 1'b0;
            lb_col_q    <= '0;
            disp_bank_q <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_prev_q    <= h_prev_d;
            pending_q   <= pending_d;
            col_q       <= col_d;
            row_base_q  <= row_base_d;
            rep_q       <= rep_d;
            lb_we_q     <= lb_we_d;
            lb_col_q    <= lb_col_d;
            disp_bank_q <= disp_bank_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (trig || pending_q) begin
                    state_d = ST_FETCH;
                end else if (wr_req) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (trig || pending_q) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (col_q == COL_LAST) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // datapath next values
    always_comb begin
        h_prev_d    = h_cnt;
        pending_d   = pending_q;
        col_d       = '0;
        row_base_d  = row_base_q;
        rep_d       = rep_q;
        lb_we_d     = (state_q == ST_FETCH);
        lb_col_d    = col_q;
        disp_bank_d = disp_bank_q;
        fetch_err_d = fetch_err_q | (trig && fetching);

        // Remember a trigger seen while a write owns the RAM; it is consumed
        // as soon as the FSM enters FETCH.
        if (trig && (state_q == ST_WRITE)) begin
            pending_d = 1'b1;
        end
        if (state_d == ST_FETCH && state_q != ST_FETCH) begin
            pending_d = 1'b0;
        end

        if (state_q == ST_FETCH) begin
            col_d = col_q + 8'd1;
        end

        if (state_q == ST_DRAIN) begin
            disp_bank_d = ~disp_bank_q;
        end

        // Row base advances by accumulation: V_SCALE fetches per row.
        if (v_cnt == 10'd0) begin
            row_base_d = '0;
            rep_d      = '0;
        end else if (state_q == ST_DRAIN) begin
            if (rep_q == REP_LAST) begin
                rep_d      = '0;
                row_base_d = row_base_q + ROW_STEP;
            end else begin
                rep_d = rep_q + REP_W'(1);
            end
        end
    end

    // outputs
    always_comb begin
        busy      = (state_q != ST_IDLE);
        wr_ack    = (state_q == ST_WRITE);
        ram_we    = (state_q == ST_WRITE);
        ram_addr  = '0;
        ram_wdata = '0;
        if (state_q == ST_WRITE) begin
            ram_addr  = wr_addr;
            ram_wdata = wr_data;
        end else if (state_q == ST_FETCH) begin
            ram_addr = row_base_q + {7'd0, col_q};
        end

        // Line-buffer write trails the RAM read by one cycle; fill bank is the
        // one not being displayed.
        lb_we     = lb_we_q;
        lb_addr   = lb_we_q ? {~disp_bank_q, lb_col_q} : 9'd0;
        lb_wdata  = lb_we_q ? ram_rdata : 8'd0;
        disp_bank = disp_bank_q;
        fetch_err = fetch_err_q;
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

    logic        clk_50 = 1'b0;
    logic        rst_n;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        wr_req;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'd0;
    logic        lb_we;
    logic [8:0]  lb_addr;
    logic [7:0]  lb_wdata;
    logic        disp_bank;
    logic        busy;
    logic        fetch_err;

    int   checks   = 0;
    int   failures = 0;
    logic exp_bank = 1'b0;
    int   qf_bad   = 0;

    always #5 clk_50 = ~clk_50;

    vga_fb_arbiter dut (
        .clk_50    (clk_50),
        .rst_n     (rst_n),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .lb_we     (lb_we),
        .lb_addr   (lb_addr),
        .lb_wdata  (lb_wdata),
        .disp_bank (disp_bank),
        .busy      (busy),
        .fetch_err (fetch_err)
    );

    function automatic logic [7:0] ram_fn(input logic [14:0] a);
        return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
    endfunction

    // framebuffer RAM: read data one cycle after the address
    always @(posedge clk_50) ram_rdata <= ram_fn(ram_addr);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_50);
    endtask

    // Trigger one line fetch and follow it cycle by cycle.
    task automatic run_fetch(input string tag, input logic [9:0] v, input logic [14:0] base);
        int   rd_bad = 0;
        int   lb_bad = 0;
        int   lb_cnt = 0;
        logic busy_161 = 1'b0;
        logic busy_162 = 1'b1;
        logic bank_162 = 1'b0;
        v_cnt = v;
        h_cnt = 10'd639;
        tick();
        h_cnt = 10'd640;
        exp_bank = ~exp_bank;
        for (int k = 1; k <= 162; k++) begin
            tick();
            if (k <= 160) begin
                if (busy !== 1'b1 || ram_we !== 1'b0 || ram_addr !== base + 15'(k - 1)) rd_bad++;
            end
            if (lb_we === 1'b1) begin
                lb_cnt++;
                if (k < 2 || k > 161 || lb_addr !== {exp_bank, 8'(k - 2)} ||
                    lb_wdata !== ram_fn(base + 15'(k - 2))) lb_bad++;
            end
            if (k == 161) busy_161 = busy;
            if (k == 162) begin
                busy_162 = busy;
                bank_162 = disp_bank;
            end
            if (k == 2) h_cnt = 10'd641;
        end
        check_val({tag, "_rd_bad"}, rd_bad, 0);
        check_val({tag, "_lb_cnt"}, lb_cnt, 160);
        check_val({tag, "_lb_bad"}, lb_bad, 0);
        check_val({tag, "_drain_busy"}, busy_161, 1'b1);
        check_val({tag, "_idle"}, busy_162, 1'b0);
        check_val({tag, "_bank"}, bank_162, exp_bank);
    endtask

    task automatic quick_fetch(input logic [9:0] v);
        int n = 0;
        v_cnt = v;
        h_cnt = 10'd639;
        tick();
        h_cnt = 10'd640;
        tick();
        if (busy !== 1'b1) qf_bad++;
        h_cnt = 10'd641;
        exp_bank = ~exp_bank;
        while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) qf_bad++;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check_val({tag, "_idle_timeout"}, (n >= 200), 1'b0);
    endtask

    task automatic no_trigger(input string tag, input logic [9:0] v);
        v_cnt = v;
        h_cnt = 10'd639;
        tick();
        h_cnt = 10'd640;
        tick();
        check_val({tag, "_busy0"}, busy, 1'b0);
        tick();
        check_val({tag, "_busy1"}, busy, 1'b0);
        h_cnt = 10'd641;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   first_ack;
        logic [14:0] ack_addr;
        logic [7:0]  ack_data;

        rst_n   = 1'b0;
        h_cnt   = 10'd0;
        v_cnt   = 10'd0;
        wr_req  = 1'b0;
        wr_addr = 15'd0;
        wr_data = 8'd0;
        repeat (3) tick();
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_ram_we", ram_we, 1'b0);
        check_val("rst_ram_addr", ram_addr, 15'd0);
        check_val("rst_wr_ack", wr_ack, 1'b0);
        check_val("rst_lb_we", lb_we, 1'b0);
        check_val("rst_disp_bank", disp_bank, 1'b0);
        check_val("rst_fetch_err", fetch_err, 1'b0);
        rst_n = 1'b1;
        tick();

        // single CPU write
        wr_req  = 1'b1;
        wr_addr = 15'h1234;
        wr_data = 8'hA5;
        check_val("wr_ack_early", wr_ack, 1'b0);
        tick();
        check_val("wr_ram_we", ram_we, 1'b1);
        check_val("wr_ram_addr", ram_addr, 15'h1234);
        check_val("wr_ram_wdata", ram_wdata, 8'hA5);
        check_val("wr_ack", wr_ack, 1'b1);
        wr_req = 1'b0;
        tick();
        check_val("wr_ack_pulse", wr_ack, 1'b0);
        check_val("wr_busy_done", busy, 1'b0);

        // first fetch and row advance
        h_cnt = 10'd641;
        tick();
        run_fetch("f23", 10'd23, 15'd0);
        run_fetch("f24", 10'd24, 15'd0);
        run_fetch("f25", 10'd25, 15'd0);
        run_fetch("f26", 10'd26, 15'd160);

        no_trigger("v22", 10'd22);

        // trigger and write request in the same cycle: fetch first
        v_cnt = 10'd30;
        h_cnt = 10'd639;
        tick();
        wr_req   = 1'b1;
        wr_addr  = 15'h0ABC;
        wr_data  = 8'h3C;
        h_cnt    = 10'd640;
        exp_bank = ~exp_bank;
        first_ack = 0;
        ack_addr  = '0;
        ack_data  = '0;
        for (int k = 1; k <= 170; k++) begin
            tick();
            if (k == 2) h_cnt = 10'd641;
            if (wr_ack === 1'b1) begin
                first_ack = k;
                ack_addr  = ram_addr;
                ack_data  = ram_wdata;
                wr_req    = 1'b0;
                break;
            end
        end
        check_val("coll_ack_cycle", first_ack, 163);
        check_val("coll_ack_addr", ack_addr, 15'h0ABC);
        check_val("coll_ack_data", ack_data, 8'h3C);
        tick();
        check_val("coll_ack_pulse", wr_ack, 1'b0);
        check_val("coll_bank", disp_bank, exp_bank);

        // trigger during WRITE: fetch starts right after the write
        v_cnt  = 10'd31;
        wr_req = 1'b1;
        wr_addr = 15'h0155;
        wr_data = 8'h77;
        tick();
        check_val("wt_ack", wr_ack, 1'b1);
        wr_req   = 1'b0;
        h_cnt    = 10'd640;
        exp_bank = ~exp_bank;
        tick();
        check_val("wt_fetch_busy", busy, 1'b1);
        check_val("wt_fetch_we", ram_we, 1'b0);
        check_val("wt_fetch_addr", ram_addr, 15'd160);
        check_val("wt_ack_off", wr_ack, 1'b0);
        tick();
        h_cnt = 10'd641;
        wait_idle("wt");
        check_val("wt_bank", disp_bank, exp_bank);

        // second trigger while a fetch is running
        v_cnt = 10'd40;
        h_cnt = 10'd639;
        tick();
        h_cnt    = 10'd640;
        exp_bank = ~exp_bank;
        tick();
        h_cnt = 10'd641;
        repeat (49) tick();
        h_cnt = 10'd639;
        tick();
        h_cnt = 10'd640;
        tick();
        check_val("err_set", fetch_err, 1'b1);
        check_val("err_busy", busy, 1'b1);
        h_cnt = 10'd641;
        wait_idle("err");
        check_val("err_bank", disp_bank, exp_bank);
        tick();
        check_val("err_sticky", fetch_err, 1'b1);

        // restart the frame and run down to the last framebuffer row
        v_cnt = 10'd0;
        tick();
        tick();
        for (int v = 23; v <= 453; v++) quick_fetch(10'(v));
        check_val("qf_bad", qf_bad, 0);
        check_val("qf_bank", disp_bank, exp_bank);
        run_fetch("f454", 10'd454, 15'd22880);
        no_trigger("v455", 10'd455);

        // reset in the middle of a fetch
        v_cnt = 10'd100;
        h_cnt = 10'd639;
        tick();
        h_cnt = 10'd640;
        repeat (20) tick();
        check_val("mid_lb_we", lb_we, 1'b1);
        h_cnt = 10'd641;
        rst_n = 1'b0;
        tick();
        check_val("mrst_busy", busy, 1'b0);
        check_val("mrst_lb_we", lb_we, 1'b0);
        check_val("mrst_lb_addr", lb_addr, 9'd0);
        check_val("mrst_lb_wdata", lb_wdata, 8'd0);
        check_val("mrst_ram_addr", ram_addr, 15'd0);
        check_val("mrst_ram_we", ram_we, 1'b0);
        check_val("mrst_wr_ack", wr_ack, 1'b0);
        check_val("mrst_disp_bank", disp_bank, 1'b0);
        check_val("mrst_fetch_err", fetch_err, 1'b0);
        rst_n = 1'b1;
        tick();
        tick();
        check_val("post_rst_busy", busy, 1'b0);
        check_val("post_rst_lb_we", lb_we, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
